tick_rate_sequencer: RTL and testbench

Controller that sequences the display counter datapath: divides the system clock into selectable tick rates and issues one-cycle count-enable and clear commands to the external toggle-flip-flop counter.
Provides run/pause/single-step/clear control and terminal-count handling (stop or wrap at a programmable limit).
Keeps a shadow count in lockstep with the external counter. Sits between the board switches/keys and the counter that feeds the hex display.

---
 rtl/tick_rate_sequencer.sv | 145 ++++++++++++++
 tb/tb_tick_rate_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_rate_sequencer.sv
// Tick-rate sequencer for the display counter datapath.
// Divides the clock into tick rates and drives count/clear pulses.
module tick_rate_sequencer #(
    parameter int BASE_DIV = 12500000,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       rate_sel,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    input  logic             wrap_en,
    input  logic [CNT_W-1:0] limit,
    output logic             cnt_en,
    output logic             cnt_clr_n,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state,
    output logic             done
);

    localparam int DIV_W = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BASE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       pre_q, pre_d;
    logic             en_q, en_d;
    logic             clr_n_q, clr_n_d;
    logic             done_q;
    logic             base_tick;
    logic             rate_tick;
    logic             cnt_ev;

    // Rate tick selection from the divider and prescaler.
    always_comb begin
        base_tick = (div_q == DIV_MAX);
        rate_tick = 1'b0;
        unique case (rate_sel)
            2'b00: rate_tick = 1'b1;
            2'b01: rate_tick = base_tick;
            2'b10: rate_tick = base_tick & pre_q[0];
            2'b11: rate_tick = base_tick & (pre_q == 2'd3);
        endcase
    end

    // Command decode, divider advance and count events.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        pre_d   = pre_q;
        en_d    = 1'b0;
        clr_n_d = 1'b1;
        cnt_ev  = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            div_d   = '0;
            pre_d   = '0;
            clr_n_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end else if (start) begin
                        state_d = S_RUN;
                        div_d   = '0;
                        pre_d   = '0;
                    end else if (step) begin
                        cnt_ev = 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_PAUSE;
                    end else begin
                        div_d  = base_tick ? '0 : div_q + DIV_W'(1);
                        pre_d  = base_tick ? pre_q + 2'd1 : pre_q;
                        cnt_ev = rate_tick;
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        state_d = S_PAUSE;
                    end else if (start) begin
                        state_d = S_RUN;
                    end else if (step) begin
                        cnt_ev = 1'b1;
                    end
                end
                S_DONE: state_d = S_DONE;
            endcase
            if (cnt_ev) begin
                if (count_q != limit) begin
                    count_d = count_q + CNT_W'(1);
                    en_d    = 1'b1;
                end else if (wrap_en) begin
                    count_d = '0;
                    clr_n_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            div_q   <= '0;
            pre_q   <= '0;
            en_q    <= 1'b0;
            clr_n_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            pre_q   <= pre_d;
            en_q    <= en_d;
            clr_n_q <= clr_n_d;
            done_q  <= (state_d == S_DONE);
        end
    end

    assign cnt_en    = en_q;
    assign cnt_clr_n = clr_n_q;
    assign count     = count_q;
    assign state     = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tick_rate_sequencer.sv
// Scoreboard bench for tick_rate_sequencer.
// Reference model predicts each cycle; a monitor compares on negedge.
module tb_tick_rate_sequencer;

    localparam int BD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] rate_sel = 2'b00;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       step = 1'b0;
    logic       clear = 1'b0;
    logic       wrap_en = 1'b0;
    logic [7:0] limit = 8'd0;
    logic       cnt_en;
    logic       cnt_clr_n;
    logic [7:0] count;
    logic [1:0] state;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       en;
        logic       clr_n;
        logic [7:0] cnt;
        logic [1:0] st;
        logic       dn;
    } exp_t;

    exp_t sb[$];
    bit   armed = 0;

    // model state
    int m_state = 0;
    int m_count = 0;
    int m_runcyc = 0;

    tick_rate_sequencer #(.BASE_DIV(BD), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .rate_sel(rate_sel),
        .start(start), .stop(stop), .step(step), .clear(clear),
        .wrap_en(wrap_en), .limit(limit), .cnt_en(cnt_en),
        .cnt_clr_n(cnt_clr_n), .count(count), .state(state),
        .done(done)
    );

    always #5 clock = ~clock;

    // Reference model: one count event under the terminal-count rules.
    function automatic void count_event(inout bit en, inout bit clr_n);
        if (m_count != int'(limit)) begin
            m_count = (m_count + 1) % 256;
            en = 1;
        end else if (wrap_en) begin
            m_count = 0;
            clr_n = 0;
        end else begin
            m_state = 3;
        end
    endfunction

    // Reference model: cycles spent in RUN determine base ticks.
    function automatic bit rate_tick_now();
        bit bt;
        int nbt;
        bt  = (m_runcyc % BD) == 0;
        nbt = m_runcyc / BD;
        case (rate_sel)
            2'd0: return 1;
            2'd1: return bt;
            2'd2: return bt && (nbt % 2 == 0);
            default: return bt && (nbt % 4 == 0);
        endcase
    endfunction

    always @(posedge clock) begin
        bit en;
        bit clr_n;
        exp_t e;
        if (!reset) begin
            m_state = 0;
            m_count = 0;
            m_runcyc = 0;
            armed = 0;
        end else begin
            en = 0;
            clr_n = 1;
            if (clear) begin
                m_state = 0;
                m_count = 0;
                m_runcyc = 0;
                clr_n = 0;
            end else begin
                case (m_state)
                    0: begin
                        if (stop) begin
                        end else if (start) begin
                            m_state = 1;
                            m_runcyc = 0;
                        end else if (step) count_event(en, clr_n);
                    end
                    1: begin
                        if (stop) m_state = 2;
                        else begin
                            m_runcyc++;
                            if (rate_tick_now()) count_event(en, clr_n);
                        end
                    end
                    2: begin
                        if (stop) begin
                        end else if (start) m_state = 1;
                        else if (step) count_event(en, clr_n);
                    end
                    default: begin
                    end
                endcase
            end
            e.en = en;
            e.clr_n = clr_n;
            e.cnt = 8'(m_count);
            e.st = 2'(m_state);
            e.dn = (m_state == 3);
            sb.push_back(e);
            armed = 1;
        end
    end

    // Monitor: compare DUT against the oldest prediction.
    always @(negedge clock) begin
        exp_t e;
        exp_t a;
        a = '{cnt_en, cnt_clr_n, count, state, done};
        if (!reset) begin
            checks++;
            if (a !== exp_t'{1'b0, 1'b1, 8'd0, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL rst_hold: got %h expected en=0 clr_n=1 cnt=0 st=0 dn=0", a);
            end
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL sb t=%0t: got en=%b clr_n=%b cnt=%0d st=%0d dn=%b expected en=%b clr_n=%b cnt=%0d st=%0d dn=%b",
                         $time, a.en, a.clr_n, a.cnt, a.st, a.dn,
                         e.en, e.clr_n, e.cnt, e.st, e.dn);
            end
            checks++;
            if (cnt_en && !cnt_clr_n) begin
                errors++;
                $display("FAIL excl: got en=1 clr_n=0 expected never both active");
            end
        end else if (armed) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no prediction expected one per cycle");
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse(input bit s, input bit p, input bit t, input bit c);
        start = s;
        stop = p;
        step = t;
        clear = c;
        cyc(1);
        start = 0;
        stop = 0;
        step = 0;
        clear = 0;
    endtask

    initial begin
        cyc(2);
        reset = 1;
        cyc(2);

        // run to limit 5 and stop there
        limit = 8'd5; wrap_en = 0; rate_sel = 2'b00;
        pulse(1, 0, 0, 0);
        cyc(10);
        checks++;
        if (done !== 1'b1 || count !== 8'd5) begin
            errors++;
            $display("FAIL done_at_limit: got done=%b cnt=%0d expected done=1 cnt=5", done, count);
        end
        pulse(0, 0, 0, 1);
        cyc(2);

        // base-tick rate, then every 4th base tick
        limit = 8'd255; rate_sel = 2'b01;
        pulse(1, 0, 0, 0);
        cyc(21);
        rate_sel = 2'b11;
        cyc(50);
        rate_sel = 2'b10;
        cyc(20);
        pulse(0, 0, 0, 1);
        cyc(2);

        // wrap at limit 2
        limit = 8'd2; wrap_en = 1; rate_sel = 2'b00;
        pulse(1, 0, 0, 0);
        cyc(10);
        pulse(0, 0, 0, 1);
        cyc(2);

        // pause and single-step
        limit = 8'd40; wrap_en = 0; rate_sel = 2'b01;
        pulse(1, 0, 0, 0);
        cyc(13);
        pulse(0, 1, 0, 0);
        cyc(4);
        repeat (3) begin
            pulse(0, 0, 1, 0);
            cyc(1);
        end
        checks++;
        if (count !== 8'd6 || state !== 2'b10) begin
            errors++;
            $display("FAIL pause_step: got cnt=%0d st=%0d expected cnt=6 st=2", count, state);
        end
        pulse(1, 0, 0, 0);
        cyc(10);
        pulse(0, 0, 0, 1);
        cyc(2);

        // clear wins over start and step
        limit = 8'd50; rate_sel = 2'b00;
        pulse(1, 0, 0, 0);
        cyc(6);
        pulse(1, 0, 1, 1);
        cyc(3);

        // async reset between edges
        pulse(1, 0, 0, 0);
        cyc(8);
        @(posedge clock);
        #3;
        reset = 0;
        sb.delete();
        #1;
        checks++;
        if ({cnt_en, cnt_clr_n, count, state, done} !== {1'b0, 1'b1, 8'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_rst: got en=%b clr_n=%b cnt=%0d st=%0d dn=%b expected reset values",
                     cnt_en, cnt_clr_n, count, state, done);
        end
        cyc(2);
        reset = 1;
        cyc(1);
        pulse(1, 0, 0, 0);
        cyc(5);

        // limit 0 edge cases
        pulse(0, 0, 0, 1);
        limit = 8'd0; wrap_en = 1;
        pulse(0, 0, 1, 0);
        cyc(1);
        wrap_en = 0;
        pulse(0, 0, 1, 0);
        cyc(2);
        pulse(0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            clear = (r < 2);
            stop  = (r >= 2 && r < 6);
            start = (r >= 6 && r < 14);
            step  = (r >= 14 && r < 22);
            if ($urandom_range(0, 63) == 0) rate_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 127) == 0) limit = 8'($urandom_range(0, 20));
            if ($urandom_range(0, 127) == 0) wrap_en = 1'($urandom_range(0, 1));
            cyc(1);
        end
        start = 0; stop = 0; step = 0; clear = 0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
